// File: rtl/pingpong_ram.sv
// Double-buffered RAM: the producer fills one bank while the consumer
// drains the other; banks change hands on wr_done / rd_done pulses.
module pingpong_ram #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 7,
  parameter int MEM_SIZE   = 128,
  parameter int OUT_REG    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_done,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_avail,
  input  logic                  rd_done,
  output logic                  err
);

  localparam logic [ADDR_WIDTH:0] SIZE =
    (ADDR_WIDTH+1)'(MEM_SIZE);

  logic [DATA_WIDTH-1:0] mem0 [MEM_SIZE];
  logic [DATA_WIDTH-1:0] mem1 [MEM_SIZE];

  logic                  wr_sel;
  logic                  rd_sel;
  logic [1:0]            cnt;

  logic                  wr_acc;
  logic                  wd_acc;
  logic                  rd_acc;
  logic                  rdn_acc;
  logic                  rd_oor;
  logic                  err_ev;

  logic                  v1;
  logic                  z1;
  logic                  s1;
  logic [DATA_WIDTH-1:0] q0;
  logic [DATA_WIDTH-1:0] q1;
  logic [DATA_WIDTH-1:0] word1;

  assign wr_ready = (cnt < 2'd2);
  assign rd_avail = (cnt != 2'd0);

  assign wr_acc  = !rst && wr_en && wr_ready
                   && ({1'b0, wr_addr} < SIZE);
  assign wd_acc  = wr_done && wr_ready;
  assign rdn_acc = rd_done && rd_avail;
  assign rd_acc  = rd_en && rd_avail;
  assign rd_oor  = !({1'b0, rd_addr} < SIZE);

  assign err_ev = (wr_en   && !wr_ready)
               || (wr_done && !wr_ready)
               || (rd_en   && !rd_avail)
               || (rd_done && !rd_avail);

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      if (wr_sel) mem1[wr_addr] <= wr_data;
      else        mem0[wr_addr] <= wr_data;
    end
  end

  // Both banks read in parallel; s1 picks the bank afterwards.
  always_ff @(posedge clk) begin
    if (!rst && rd_acc) begin
      q0 <= mem0[rd_addr];
      q1 <= mem1[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      cnt    <= 2'd0;
      err    <= 1'b0;
      v1     <= 1'b0;
      z1     <= 1'b1;
      s1     <= 1'b0;
    end else begin
      if (wd_acc)  wr_sel <= ~wr_sel;
      if (rdn_acc) rd_sel <= ~rd_sel;
      case ({wd_acc, rdn_acc})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
      v1 <= rd_acc;
      if (rd_acc) begin
        z1 <= rd_oor;
        s1 <= rd_sel;
      end
      if (err_ev) err <= 1'b1;
    end
  end

  // z1 also forces zero after reset until the first accepted read.
  assign word1 = z1 ? '0 : (s1 ? q1 : q0);

  if (OUT_REG != 0) begin : g_oreg
    logic                  v2;
    logic [DATA_WIDTH-1:0] d2;

    always_ff @(posedge clk) begin
      if (rst) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= v1;
        if (v1) d2 <= word1;
      end
    end

    assign rd_valid = v2;
    assign rd_data  = d2;
  end else begin : g_direct
    assign rd_valid = v1;
    assign rd_data  = word1;
  end

endmodule

// File: tb/tb_pingpong_ram.sv
// Directed bench for pingpong_ram: default, registered-output
// and MEM_SIZE=100 instances share one stimulus stream.
module tb_pingpong_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [19:0] wr_data;
  logic        wr_done;
  logic        rd_en;
  logic [6:0]  rd_addr;
  logic        rd_done;

  logic        wrdy_a, ravl_a, val_a, err_a;
  logic [19:0] dat_a;
  logic        wrdy_r, ravl_r, val_r, err_r;
  logic [19:0] dat_r;
  logic        wrdy_s, ravl_s, val_s, err_s;
  logic [19:0] dat_s;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  pingpong_ram #(.OUT_REG(0)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_done(wr_done), .wr_ready(wrdy_a),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(dat_a),
    .rd_valid(val_a), .rd_avail(ravl_a),
    .rd_done(rd_done), .err(err_a)
  );

  pingpong_ram #(.OUT_REG(1)) dut_r (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_done(wr_done), .wr_ready(wrdy_r),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(dat_r),
    .rd_valid(val_r), .rd_avail(ravl_r),
    .rd_done(rd_done), .err(err_r)
  );

  pingpong_ram #(.MEM_SIZE(100)) dut_s (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_done(wr_done), .wr_ready(wrdy_s),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(dat_s),
    .rd_valid(val_s), .rd_avail(ravl_s),
    .rd_done(rd_done), .err(err_s)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [6:0]  wa;
    logic [19:0] wd;
    logic        wdn;
    logic        re;
    logic [6:0]  ra;
    logic        rdn;
    logic        x_wrdy;
    logic        x_ravl;
    logic        x_val;
    logic [19:0] x_dat;
    logic        x_err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic we,
                     input int wa, input int wd,
                     input logic wdn, input logic re,
                     input int ra, input logic rdn,
                     input logic xw, input logic xa,
                     input logic xv, input int xd,
                     input logic xe);
    vec_t v;
    v.rst = r;  v.we = we;
    v.wa = 7'(wa);  v.wd = 20'(wd);
    v.wdn = wdn;  v.re = re;
    v.ra = 7'(ra);  v.rdn = rdn;
    v.x_wrdy = xw;  v.x_ravl = xa;
    v.x_val = xv;  v.x_dat = 20'(xd);
    v.x_err = xe;
    vq.push_back(v);
  endtask

  task automatic idle();
    rst = 1'b0;  wr_en = 1'b0;  wr_addr = '0;
    wr_data = '0;  wr_done = 1'b0;  rd_en = 1'b0;
    rd_addr = '0;  rd_done = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %0h expected %0h",
               nm, idx, act, exp);
    end
  endtask

  logic        prev_v;
  logic [19:0] prev_d;
  logic        ev;
  logic [19:0] ed;

  initial begin
    // --- table rows: bank handoff, full/empty, reset mid-burst ---
    add(1,0,0,0,    0,0,0,0, 1,0,0,0,    0);
    add(0,1,3,'h11, 0,0,0,0, 1,0,0,0,    0);
    add(0,0,0,0,    1,0,0,0, 1,1,0,0,    0);
    add(0,1,3,'h22, 1,0,0,0, 0,1,0,0,    0);
    add(0,1,3,'h33, 0,0,0,0, 0,1,0,0,    1);
    add(0,0,0,0,    1,0,0,0, 0,1,0,0,    1);
    add(0,0,0,0,    0,1,3,0, 0,1,1,'h11, 1);
    add(0,0,0,0,    0,1,3,1, 1,1,1,'h11, 1);
    add(0,0,0,0,    0,1,3,0, 1,1,1,'h22, 1);
    add(0,0,0,0,    0,0,0,0, 1,1,0,'h22, 1);
    add(0,1,3,'h44, 0,0,0,0, 1,1,0,'h22, 1);
    add(0,0,0,0,    1,0,0,1, 1,1,0,'h22, 1);
    add(0,0,0,0,    0,1,3,0, 1,1,1,'h44, 1);
    add(0,0,0,0,    0,0,0,1, 1,0,0,'h44, 1);
    add(1,0,0,0,    0,0,0,0, 1,0,0,0,    0);
    for (int i = 0; i < 8; i++)
      add(0,1,i,'h100+i, 0,0,0,0, 1,0,0,0, 0);
    add(0,0,0,0,    1,0,0,0, 1,1,0,0,     0);
    add(0,0,0,0,    0,1,0,0, 1,1,1,'h100, 0);
    add(0,0,0,0,    0,1,1,0, 1,1,1,'h101, 0);
    add(0,0,0,0,    0,1,2,0, 1,1,1,'h102, 0);
    add(1,0,0,0,    0,1,3,0, 1,0,0,0,     0);
    add(0,0,0,0,    0,0,0,0, 1,0,0,0,     0);
    add(0,0,0,0,    0,0,0,0, 1,0,0,0,     0);

    // --- fill one bank, read latency, out-of-range read ---
    idle();
    rst = 1'b1;
    cycle();
    cycle();
    chk("rst wr_ready", 0, wrdy_a, 1);
    chk("rst rd_avail", 0, ravl_a, 0);
    chk("rst rd_valid", 0, val_a, 0);
    chk("rst rd_data", 0, dat_a, 0);
    chk("rst err", 0, err_a, 0);
    chk("rst rd_valid r", 0, val_r, 0);
    rst = 1'b0;
    for (int a = 0; a < 128; a++) begin
      wr_en = 1'b1;
      wr_addr = 7'(a);
      wr_data = 20'(1000 + a);
      cycle();
    end
    idle();
    wr_done = 1'b1;
    cycle();
    idle();
    chk("commit rd_avail", 0, ravl_a, 1);
    chk("commit wr_ready", 0, wrdy_a, 1);
    chk("commit rd_avail r", 0, ravl_r, 1);
    rd_en = 1'b1;
    rd_addr = 7'd5;
    cycle();
    chk("lat1 valid", 0, val_a, 1);
    chk("lat1 data", 0, dat_a, 1005);
    chk("lat1 valid r", 0, val_r, 0);
    chk("lat1 valid s", 0, val_s, 1);
    chk("lat1 data s", 0, dat_s, 1005);
    rd_addr = 7'd127;
    cycle();
    idle();
    chk("a127 valid", 0, val_a, 1);
    chk("a127 data", 0, dat_a, 1127);
    chk("lat2 valid r", 0, val_r, 1);
    chk("lat2 data r", 0, dat_r, 1005);
    chk("oor valid s", 0, val_s, 1);
    chk("oor data s", 0, dat_s, 0);
    chk("oor err s", 0, err_s, 0);
    cycle();
    chk("hold valid", 0, val_a, 0);
    chk("hold data", 0, dat_a, 1127);
    chk("a127 valid r", 0, val_r, 1);
    chk("a127 data r", 0, dat_r, 1127);
    rd_done = 1'b1;
    cycle();
    idle();
    chk("release rd_avail", 0, ravl_a, 0);
    chk("release err", 0, err_a, 0);
    chk("release valid r", 0, val_r, 0);
    rd_en = 1'b1;
    rd_addr = 7'd5;
    cycle();
    idle();
    chk("empty rd valid", 0, val_a, 0);
    chk("empty rd data", 0, dat_a, 1127);
    chk("empty rd err", 0, err_a, 1);
    cycle();
    chk("empty rd valid r", 0, val_r, 0);
    chk("empty rd data r", 0, dat_r, 1127);

    // --- table replay ---
    prev_v = 1'b0;
    prev_d = '0;
    foreach (vq[i]) begin
      rst = vq[i].rst;
      wr_en = vq[i].we;
      wr_addr = vq[i].wa;
      wr_data = vq[i].wd;
      wr_done = vq[i].wdn;
      rd_en = vq[i].re;
      rd_addr = vq[i].ra;
      rd_done = vq[i].rdn;
      cycle();
      chk("wr_ready", i, wrdy_a, vq[i].x_wrdy);
      chk("rd_avail", i, ravl_a, vq[i].x_ravl);
      chk("rd_valid", i, val_a, vq[i].x_val);
      chk("rd_data", i, dat_a, vq[i].x_dat);
      chk("err", i, err_a, vq[i].x_err);
      chk("rd_valid s", i, val_s, vq[i].x_val);
      chk("rd_data s", i, dat_s, vq[i].x_dat);
      // registered output lags the direct path by one row
      ev = vq[i].rst ? 1'b0 : prev_v;
      ed = vq[i].rst ? '0 : prev_d;
      chk("wr_ready r", i, wrdy_r, vq[i].x_wrdy);
      chk("err r", i, err_r, vq[i].x_err);
      chk("rd_valid r", i, val_r, ev);
      chk("rd_data r", i, dat_r, ed);
      prev_v = vq[i].x_val;
      prev_d = vq[i].x_dat;
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
